mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter MEM_SIZE, default 4096: byte capacity of the data store.
REQ-002 Parameter ADDR_WIDTH, default 32: request address width.
REQ-003 Parameter DATA_WIDTH, default 32: write and read data width.
REQ-004 Parameter LATENCY, default 3, legal range 1..15: cycles from request acceptance to the first resp_valid cycle.
REQ-005 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port req_valid, input, 1: the processor presents a request.
REQ-008 Port req_ready, output, 1: the responder can accept a request.
REQ-009 Port req_write, input, 1: 1 = store, 0 = load.
REQ-010 Port req_addr, input, ADDR_WIDTH: byte address.
REQ-011 Port req_size, input, 2: access_size_t; BYTE=00, SHORT=01, WORD=10, 11 is illegal.
REQ-012 Port req_wdata, input, DATA_WIDTH: store data, low-aligned.
REQ-013 Port resp_valid, output, 1: a response is presented.
REQ-014 Port resp_ready, input, 1: the processor accepts the response.
REQ-015 Port resp_rdata, output, DATA_WIDTH: load data, zero-extended; 0 for stores and errors.
REQ-016 Port resp_error, output, 1: the request was rejected.

Function
REQ-017 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-018 req_ready SHALL be 1 only in IDLE, and it SHALL be driven combinationally from the state.
REQ-019 A request SHALL be accepted when req_valid and req_ready are both high at a rising edge.
REQ-020 On acceptance, the block SHALL latch write, addr, size and wdata; later changes on req_* SHALL be ignored until the block returns to IDLE.
REQ-021 Latency: if the handshake occurs in cycle c, resp_valid SHALL first be high in cycle c+LATENCY.
REQ-022 State transitions:
- With LATENCY=1: IDLE goes directly to RESP.
- Otherwise: IDLE to BUSY, with the cycle counter loaded to LATENCY-1.
- BUSY decrements the counter and moves to RESP on the edge where the counter equals 1.
REQ-023 The memory access SHALL be performed on the edge that enters RESP.
- resp_rdata and resp_error SHALL be registered at that same edge.
- They SHALL stay stable throughout RESP.
REQ-024 In RESP, resp_valid SHALL be 1; resp_valid & resp_ready at an edge SHALL return the FSM to IDLE.
- While resp_ready is low, the block SHALL hold RESP indefinitely.
REQ-025 Minimum request-to-request spacing SHALL be LATENCY+1 cycles; there is no overlap or pipelining.
REQ-026 Byte order SHALL be little-endian: byte addr holds bits 7:0, and addr+1 holds bits 15:8.
REQ-027 Load results:
- BYTE SHALL return {24'b0, mem[a]}.
- SHORT SHALL return {16'b0, mem[a+1], mem[a]}.
- WORD SHALL return 4 bytes.
REQ-028 A store SHALL write only the 1, 2 or 4 low bytes of wdata; the remaining bytes of the word are untouched.
REQ-029 resp_error SHALL be 1 when any of the following holds:
- size is 11;
- SHORT with addr[0]=1;
- WORD with addr[1:0]≠0;
- addr+bytes > MEM_SIZE, evaluated without wrap-around in ADDR_WIDTH+1 bits.
REQ-030 An errored store SHALL NOT modify memory, and an errored load SHALL return rdata 0.

Reset
REQ-031 When rst is high at an edge:
- the state SHALL go to IDLE and the counter to 0;
- resp_valid, resp_error and resp_rdata SHALL all go to 0;
- req_ready SHALL be 1 in the cycle after reset.
REQ-032 Reset SHALL take priority over every simultaneous handshake or transition.
REQ-033 Reset in BUSY SHALL abandon the request without any memory write.
REQ-034 Memory contents SHALL NOT be reset.

Verification (LATENCY=3)
REQ-035 Write-then-read: WORD store 0xDEADBEEF at 0x10 with handshake in cycle c, then WORD load at 0x10.
- Store response: resp_valid first high in cycle c+3, error=0, rdata=0.
- Load response: rdata=0xDEADBEEF.
REQ-036 Sub-word loads after REQ-035:
- BYTE load at 0x11 SHALL return 0x000000BE.
- SHORT load at 0x12 SHALL return 0x0000DEAD.
REQ-037 Partial store: BYTE store with wdata=0x123456FF at 0x13, then WORD load at 0x10, SHALL return 0xFFADBEEF.
REQ-038 Error cases, each SHALL give resp_error=1 and rdata=0:
- WORD load at 0x0FFE;
- WORD store at 0x1000;
- SHORT load at 0x21;
- size 11.
- Afterwards, a WORD load at 0x10 SHALL still return 0xFFADBEEF.
REQ-039 Backpressure: hold resp_ready low for 5 cycles during RESP.
- resp_valid and resp_rdata SHALL remain stable, and req_ready SHALL be 0.
- After resp_ready rises, the next request SHALL be accepted one cycle later.
REQ-040 Reset mid-operation: pre-store 0 at 0x30, then WORD store 0x11111111 at 0x30 and assert rst in its BUSY cycle.
- After reset, resp_valid SHALL be 0 and req_ready SHALL be 1.
- A WORD load at 0x30 SHALL return 0x00000000.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder -- single-outstanding memory responder with fixed latency.
//
// Accepts one load/store request at a time over a valid/ready handshake.
// Stores and loads go to a byte-addressed little-endian data store. The
// response appears a fixed LATENCY cycles after acceptance and is held until
// the requester takes it.
//
// Ports
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   req_valid   in   request presented
//   req_ready   out  responder idle, can accept
//   req_write   in   1 = store, 0 = load
//   req_addr    in   byte address
//   req_size    in   00 byte, 01 short, 10 word, 11 illegal
//   req_wdata   in   store data, low-aligned
//   resp_valid  out  response presented
//   resp_ready  in   requester takes the response
//   resp_rdata  out  load data zero-extended, 0 for stores and errors
//   resp_error  out  request rejected
//
// The byte lanes assume DATA_WIDTH >= 32.
module mem_responder #(
    parameter int MEM_SIZE   = 4096,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error
);

    localparam int MEM_AW = $clog2(MEM_SIZE);
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  error_q;

    logic [7:0] mem [MEM_SIZE];

    logic                  accept;
    logic                  enter_resp;
    logic                  acc_write;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [1:0]            acc_size;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [2:0]            nbytes;
    logic [ADDR_WIDTH:0]   end_addr;
    logic                  acc_err;
    logic [MEM_AW-1:0]     base;
    logic [31:0]           rd_word;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_error = error_q;
    assign accept     = req_valid && req_ready;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    // With LATENCY=1 the access happens on the accepting edge itself, before
    // the latched copy exists, so the live request is used while still IDLE.
    always_comb begin
        if (state_q == IDLE) begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_size  = req_size;
            acc_wdata = req_wdata;
        end else begin
            acc_write = write_q;
            acc_addr  = addr_q;
            acc_size  = size_q;
            acc_wdata = wdata_q;
        end
    end

    always_comb begin
        case (acc_size)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            2'b10:   nbytes = 3'd4;
            default: nbytes = 3'd0;
        endcase
    end

    // End address is formed one bit wider so a request near the top of the
    // address space cannot wrap and look in range.
    assign end_addr = {1'b0, acc_addr} + (ADDR_WIDTH+1)'(nbytes);

    always_comb begin
        acc_err = 1'b0;
        if (acc_size == 2'b11)                          acc_err = 1'b1;
        if (acc_size == 2'b01 && acc_addr[0])           acc_err = 1'b1;
        if (acc_size == 2'b10 && acc_addr[1:0] != 2'b0) acc_err = 1'b1;
        if (end_addr > MEM_LIMIT)                       acc_err = 1'b1;
    end

    assign base = acc_addr[MEM_AW-1:0];

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < nbytes) begin
                rd_word[8*i +: 8] = mem[base + MEM_AW'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (enter_resp) begin
                error_q <= acc_err;
                rdata_q <= (!acc_write && !acc_err) ? DATA_WIDTH'(rd_word) : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            size_q  <= req_size;
            wdata_q <= req_wdata;
        end
    end

    // Memory is never reset; a reset arriving before RESP drops the store.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && acc_write && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < nbytes) begin
                    mem[base + MEM_AW'(i)] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
